// File: rtl/char_out_driver_if.sv
// CPU-to-display character channel: write port toward the FIFO plus the
// display-side strobe/clear/status signals produced by char_out_driver.
interface char_out_driver_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       addInput;
  logic [6:0] charCode;
  logic       clear;
  logic [4:0] col;
  logic       busy;

  // Producer side: writes bytes, observes status and display strobes.
  modport master (
    output wr_en, wr_data,
    input  full, empty, addInput, charCode, clear, col, busy
  );

  // Driver side: consumes bytes, generates display strobes.
  modport slave (
    input  wr_en, wr_data,
    output full, empty, addInput, charCode, clear, col, busy
  );
endinterface

// File: rtl/char_out_driver.sv
// Character output driver: buffers CPU bytes in a FIFO and replays them to a
// character display as addInput strobes separated by gaps, issuing a display
// clear on form-feed/newline or (optionally) before the 17th character.
module char_out_driver #(
  parameter int DEPTH      = 8,
  parameter int HOLD       = 2,
  parameter int AUTO_CLEAR = 1
) (
  input logic              clk_50,
  input logic              reset_n,
  char_out_driver_if.slave bus
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              HW        = $clog2(HOLD + 1);
  localparam logic [AW:0]     FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, STROBE, GAP, CLEAR} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          add_q, add_d;
  logic          clr_q, clr_d;
  logic          busy_q, busy_d;
  logic [6:0]    code_q, code_d;
  logic [4:0]    col_q, col_d;

  logic          push;
  logic          pop;
  logic          full_w;
  logic          empty_w;
  logic [7:0]    head;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  function automatic logic is_clear_code(input logic [7:0] b);
    return (b == 8'h0A) || (b == 8'h0C);
  endfunction

  // Column advance: saturate at 16 when auto-clear handles overflow,
  // otherwise follow the display's own 4-bit wrap.
  function automatic logic [4:0] col_inc(input logic [4:0] c);
    if (AUTO_CLEAR != 0) begin
      return (c >= 5'd16) ? 5'd16 : c + 5'd1;
    end
    return {1'b0, c[3:0] + 4'd1};
  endfunction

  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);
  // A write while full is dropped outright, even if a pop frees a slot now.
  assign push    = bus.wr_en && !full_w;
  assign head    = mem_q[rd_ptr_q];

  // FIFO storage: payload only, never needs a reset value.
  always_ff @(posedge clk_50) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel in count.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state logic: classify the head byte in IDLE, time each phase by HOLD.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    code_d  = code_q;
    col_d   = col_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_w) begin
          if ((AUTO_CLEAR != 0) && (col_q == 5'd16) && is_printable(head)) begin
            // Line is full: clear first, keep the byte for the next pass.
            state_d = CLEAR;
            hold_d  = '0;
            col_d   = '0;
          end else begin
            pop = 1'b1;
            if (is_clear_code(head)) begin
              state_d = CLEAR;
              hold_d  = '0;
              col_d   = '0;
            end else if (is_printable(head)) begin
              state_d = STROBE;
              hold_d  = '0;
              code_d  = head[6:0];
            end
          end
        end
      end
      STROBE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = GAP;
          hold_d  = '0;
          col_d   = col_inc(col_q);
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      GAP, CLEAR: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    add_d  = (state_d == STROBE);
    clr_d  = (state_d == CLEAR);
    busy_d = (state_d != IDLE);
  end

  // State and registered display outputs.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      add_q   <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      code_q  <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      add_q   <= add_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      code_q  <= code_d;
      col_q   <= col_d;
    end
  end

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.addInput = add_q;
  assign bus.clear    = clr_q;
  assign bus.charCode = code_q;
  assign bus.col      = col_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_char_out_driver.sv
// Scoreboard bench for char_out_driver: stimulus pushes expected display
// events, a negedge monitor pops and compares them as strobes/clears appear.
module tb_char_out_driver;

  localparam int H0 = 2;
  localparam int H1 = 16;

  typedef struct packed {
    logic       is_clr;
    logic [6:0] code;
    logic [4:0] col;
  } ev_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ev_t exp_q0[$];
  ev_t exp_q1[$];
  int  rises0[$];
  int  rises1[$];

  bit         prev_ai [2];
  bit         prev_cl [2];
  int         wid_ai  [2];
  int         wid_cl  [2];
  logic [4:0] pend_col[2];

  char_out_driver_if b0 ();
  char_out_driver_if b1 ();

  char_out_driver #(.DEPTH(8), .HOLD(H0), .AUTO_CLEAR(1)) dut0 (
    .clk_50 (clk),
    .reset_n(rst0),
    .bus    (b0)
  );

  char_out_driver #(.DEPTH(8), .HOLD(H1), .AUTO_CLEAR(1)) dut1 (
    .clk_50 (clk),
    .reset_n(rst1),
    .bus    (b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int hold_of(input int w);
    return (w == 0) ? H0 : H1;
  endfunction
  function automatic logic full_of(input int w);
    return (w == 0) ? b0.full : b1.full;
  endfunction
  function automatic logic empty_of(input int w);
    return (w == 0) ? b0.empty : b1.empty;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? b0.busy : b1.busy;
  endfunction
  function automatic logic ai_of(input int w);
    return (w == 0) ? b0.addInput : b1.addInput;
  endfunction
  function automatic logic [4:0] col_of(input int w);
    return (w == 0) ? b0.col : b1.col;
  endfunction

  task automatic push_exp(input int w, input logic is_clr, input logic [6:0] code,
                          input logic [4:0] col);
    ev_t e;
    e.is_clr = is_clr;
    e.code   = code;
    e.col    = col;
    if (w == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic pop_exp(input int w, output ev_t e, output bit got);
    e   = '0;
    got = 1'b0;
    if (w == 0) begin
      if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); got = 1'b1; end
    end else begin
      if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
    end
  endtask

  // Monitor step for one DUT: pops an expected event on every rising edge of
  // addInput or clear and checks pulse width and column on the falling edge.
  task automatic mon_step(input int w, input logic rn, input logic ai, input logic cl,
                          input logic [6:0] cc, input logic [4:0] col, input logic bz);
    ev_t e;
    bit  got;
    if (!rn) begin
      prev_ai[w] = 1'b0;
      prev_cl[w] = 1'b0;
      wid_ai[w]  = 0;
      wid_cl[w]  = 0;
      return;
    end
    if (ai && !prev_ai[w]) begin
      pop_exp(w, e, got);
      chk("strobe_expected", int'(got), 1);
      if (got) begin
        chk("strobe_kind", int'(e.is_clr), 0);
        chk("charCode", int'(cc), int'(e.code));
        pend_col[w] = e.col;
      end
      chk("strobe_clear_exclusive", int'(cl), 0);
      chk("busy_in_strobe", int'(bz), 1);
      if (w == 0) rises0.push_back(cyc);
      else        rises1.push_back(cyc);
      wid_ai[w] = 1;
    end else if (ai) begin
      wid_ai[w]++;
    end else if (prev_ai[w]) begin
      chk("strobe_width", wid_ai[w], hold_of(w));
      chk("col_after_strobe", int'(col), int'(pend_col[w]));
    end
    if (cl && !prev_cl[w]) begin
      pop_exp(w, e, got);
      chk("clear_expected", int'(got), 1);
      if (got) chk("clear_kind", int'(e.is_clr), 1);
      chk("col_in_clear", int'(col), 0);
      chk("busy_in_clear", int'(bz), 1);
      wid_cl[w] = 1;
    end else if (cl) begin
      wid_cl[w]++;
    end else if (prev_cl[w]) begin
      chk("clear_width", wid_cl[w], hold_of(w));
    end
    prev_ai[w] = ai;
    prev_cl[w] = cl;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_step(0, rst0, b0.addInput, b0.clear, b0.charCode, b0.col, b0.busy);
      mon_step(1, rst1, b1.addInput, b1.clear, b1.charCode, b1.col, b1.busy);
    end
  end

  // One-cycle write; call #1 after a rising edge, returns #1 after the next.
  task automatic wr(input int w, input logic [7:0] b);
    if (w == 0) begin b0.wr_en = 1'b1; b0.wr_data = b; end
    else        begin b1.wr_en = 1'b1; b1.wr_data = b; end
    @(posedge clk);
    #1;
    if (w == 0) b0.wr_en = 1'b0;
    else        b1.wr_en = 1'b0;
  endtask

  task automatic wr_fc(input int w, input logic [7:0] b);
    int t = 0;
    while (full_of(w) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) chk("full_wait_timeout", 1, 0);
    wr(w, b);
  endtask

  task automatic wait_idle(input int w, input int budget);
    int t = 0;
    int stable = 0;
    while (stable < 3 && t < budget) begin
      @(negedge clk);
      t++;
      if (!busy_of(w) && empty_of(w)) stable++;
      else                            stable = 0;
    end
    chk("idle_reached", int'(stable >= 3), 1);
  endtask

  task automatic end_test(input int w);
    chk("leftover_expected", (w == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  task automatic do_reset(input int w);
    if (w == 0) rst0 = 1'b0;
    else        rst1 = 1'b0;
    repeat (3) @(posedge clk);
    if (w == 0) begin exp_q0.delete(); rises0.delete(); end
    else        begin exp_q1.delete(); rises1.delete(); end
    @(negedge clk);
    if (w == 0) rst0 = 1'b1;
    else        rst1 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int wc;
    int t;
    b0.wr_en = 1'b0; b0.wr_data = '0;
    b1.wr_en = 1'b0; b1.wr_data = '0;

    // Asynchronous reset before any clock edge.
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    #2;
    chk("rst_empty",    int'(b0.empty),    1);
    chk("rst_full",     int'(b0.full),     0);
    chk("rst_addInput", int'(b0.addInput), 0);
    chk("rst_clear",    int'(b0.clear),    0);
    chk("rst_charCode", int'(b0.charCode), 0);
    chk("rst_col",      int'(b0.col),      0);
    chk("rst_busy",     int'(b0.busy),     0);
    chk("rst1_empty",   int'(b1.empty),    1);
    do_reset(1);
    do_reset(0);

    // Single 'A': latency 2 cycles, column 1.
    push_exp(0, 1'b0, 7'h41, 5'd1);
    wc = cyc;
    wr(0, 8'h41);
    wait_idle(0, 100);
    chk("latency_A", (rises0.size() > 0) ? rises0[0] - wc : -1, 2);
    chk("col_after_A", int'(b0.col), 1);
    chk("charCode_held", int'(b0.charCode), 'h41);
    end_test(0);

    // "ABC" back to back: rising edges 2*HOLD+1 apart.
    do_reset(0);
    push_exp(0, 1'b0, 7'h41, 5'd1);
    push_exp(0, 1'b0, 7'h42, 5'd2);
    push_exp(0, 1'b0, 7'h43, 5'd3);
    wr(0, 8'h41);
    wr(0, 8'h42);
    wr(0, 8'h43);
    wait_idle(0, 100);
    chk("abc_strobes", rises0.size(), 3);
    if (rises0.size() == 3) begin
      chk("abc_spacing1", rises0[1] - rises0[0], 2 * H0 + 1);
      chk("abc_spacing2", rises0[2] - rises0[1], 2 * H0 + 1);
    end
    chk("col_after_abc", int'(b0.col), 3);
    end_test(0);

    // 17 printable bytes: 16 strobes, auto clear, then the 17th.
    do_reset(0);
    for (int i = 0; i < 16; i++) push_exp(0, 1'b0, 7'(8'h61 + i), 5'(i + 1));
    push_exp(0, 1'b1, 7'h00, 5'd0);
    push_exp(0, 1'b0, 7'h71, 5'd1);
    for (int i = 0; i < 17; i++) wr_fc(0, 8'(8'h61 + i));
    wait_idle(0, 400);
    chk("auto_clear_strobes", rises0.size(), 17);
    chk("col_after_17", int'(b0.col), 1);
    end_test(0);

    // Form feed after five characters, then non-printables are discarded.
    do_reset(0);
    for (int i = 0; i < 5; i++) push_exp(0, 1'b0, 7'(8'h41 + i), 5'(i + 1));
    push_exp(0, 1'b1, 7'h00, 5'd0);
    for (int i = 0; i < 5; i++) wr(0, 8'(8'h41 + i));
    wr(0, 8'h0C);
    wait_idle(0, 100);
    chk("col_after_ff", int'(b0.col), 0);
    wr(0, 8'h85);
    repeat (3) @(negedge clk);
    chk("discard_empty", int'(b0.empty), 1);
    chk("discard_no_strobe", int'(b0.addInput), 0);
    chk("discard_idle", int'(b0.busy), 0);
    push_exp(0, 1'b1, 7'h00, 5'd0);
    push_exp(0, 1'b0, 7'h5A, 5'd1);
    wr(0, 8'h7F);
    wr(0, 8'h07);
    wr(0, 8'h0A);
    wr(0, 8'h5A);
    wait_idle(0, 100);
    chk("strobes_ff_test", rises0.size(), 6);
    chk("col_after_Z", int'(b0.col), 1);
    end_test(0);

    // Overflow on the long-HOLD instance: 10 writes during one strobe.
    do_reset(1);
    push_exp(1, 1'b0, 7'h41, 5'd1);
    for (int i = 0; i < 8; i++) push_exp(1, 1'b0, 7'(8'h30 + i), 5'(i + 2));
    wr(1, 8'h41);
    t = 0;
    while (!b1.addInput && t < 20) begin @(negedge clk); t++; end
    chk("stall_strobe_seen", int'(b1.addInput), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) wr(1, 8'(8'h30 + i));
    chk("overflow_full", int'(b1.full), 1);
    chk("overflow_busy", int'(b1.busy), 1);
    wait_idle(1, 1000);
    chk("overflow_strobes", rises1.size(), 9);
    chk("overflow_full_after", int'(b1.full), 0);
    chk("col_after_overflow", int'(b1.col), 9);
    end_test(1);

    // Reset in the first STROBE cycle aborts everything.
    do_reset(0);
    push_exp(0, 1'b0, 7'h41, 5'd1);
    wr(0, 8'h41);
    wr(0, 8'h42);
    wr(0, 8'h43);
    t = 0;
    while (!b0.addInput && t < 20) begin @(negedge clk); t++; end
    chk("abort_strobe_seen", int'(b0.addInput), 1);
    #1;
    rst0 = 1'b0;
    #1;
    chk("abort_addInput", int'(b0.addInput), 0);
    chk("abort_empty",    int'(b0.empty),    1);
    chk("abort_col",      int'(b0.col),      0);
    chk("abort_busy",     int'(b0.busy),     0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_more_strobes", rises0.size(), 1);
    chk("abort_col_after", int'(b0.col), 0);
    chk("abort_empty_after", int'(b0.empty), 1);
    end_test(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
